// File: rtl/audio_i2s_pkg.sv
// Shared constants, types and slot helpers for the I2S codec interface.
// Frame timing is fixed: 256 clk12 cycles per stereo frame, 4 cycles per bit slot.
package audio_i2s_pkg;

  localparam int unsigned FRAME_CYCLES   = 256;
  localparam int unsigned BCLK_DIV       = 4;
  localparam int unsigned SAMPLE_BITS    = 16;
  localparam int unsigned SLOTS_PER_HALF = 32;

  localparam int unsigned CNT_W   = $clog2(FRAME_CYCLES);
  localparam int unsigned PHASE_W = $clog2(BCLK_DIV);
  localparam int unsigned SLOT_W  = $clog2(SLOTS_PER_HALF);

  localparam logic [CNT_W-1:0] LEFT_END  = CNT_W'(FRAME_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_CYCLES - 1);

  typedef logic [SAMPLE_BITS-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // Position of clk12 within one bit clock period.
  typedef enum logic [PHASE_W-1:0] {
    PH_FALL = 2'd0,
    PH_LOW  = 2'd1,
    PH_RISE = 2'd2,
    PH_HIGH = 2'd3
  } bclk_phase_e;

  function automatic logic is_data_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= 5'd1) && (slot <= 5'd16);
  endfunction

  // Slot 0 is the I2S one-bit delay; slots 1..16 carry the sample MSB first.
  function automatic logic slot_bit(input sample_t s, input logic [SLOT_W-1:0] slot);
    logic [3:0] idx;
    idx = 4'(5'd16 - slot);
    if (is_data_slot(slot)) begin
      return s[idx];
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/audio_tone_gen.sv
// Square-wave tone source: holds +/-AMPLITUDE and flips polarity every
// TONE_HALF_FRAMES frame ticks.
module audio_tone_gen
  import audio_i2s_pkg::*;
#(
  parameter int unsigned TONE_HALF_FRAMES = 48,
  parameter sample_t     AMPLITUDE        = 16'h2000
) (
  input  logic    clk12,
  input  logic    reset12_,
  input  logic    frame_tick,
  output sample_t sample
);

  localparam logic [9:0] LAST_FRAME    = 10'(TONE_HALF_FRAMES - 1);
  localparam sample_t    NEG_AMPLITUDE = 16'h0000 - AMPLITUDE;

  logic [9:0] frame_cnt_r;
  logic       polarity_r;
  sample_t    sample_r;

  function automatic sample_t tone_level(input logic pol);
    if (pol) begin
      return NEG_AMPLITUDE;
    end else begin
      return AMPLITUDE;
    end
  endfunction

  // Half-period frame counter; sample_r always mirrors the current polarity.
  always_ff @(posedge clk12) begin
    if (!reset12_) begin
      frame_cnt_r <= 10'd0;
      polarity_r  <= 1'b0;
      sample_r    <= AMPLITUDE;
    end else if (frame_tick) begin
      if (frame_cnt_r == LAST_FRAME) begin
        frame_cnt_r <= 10'd0;
        polarity_r  <= ~polarity_r;
        sample_r    <= tone_level(~polarity_r);
      end else begin
        frame_cnt_r <= frame_cnt_r + 10'd1;
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign sample = sample_r;

endmodule

// File: rtl/audio_i2s_if.sv
// I2S master for the audio codec: derives bit/LR clocks from a 256-cycle frame
// counter, serialises the DAC stereo sample and captures the ADC stream.
module audio_i2s_if
  import audio_i2s_pkg::*;
#(
  parameter bit          LOOPBACK         = 1'b0,
  parameter int unsigned TONE_HALF_FRAMES = 48,
  parameter sample_t     AMPLITUDE        = 16'h2000
) (
  input  logic clk12,
  input  logic reset12_,
  output logic audio_mclk,
  output logic audio_bclk,
  output logic audio_daclrc,
  output logic audio_dacdat,
  output logic audio_adclrc,
  input  logic audio_adcdat
);

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [SLOT_W-1:0] slot_s;
  logic [SLOT_W-1:0] slot_next_s;
  logic              bclk_r;
  logic              lrc_r;
  logic              dacdat_r;
  logic              capture_s;
  logic              frame_tick_s;
  sample_t           shift_r;
  sample_t           tone_s;
  sample_t           dac_word_s;
  stereo_t           adc_r;
  stereo_t           dac_r;
  stereo_t           dac_load_s;

  audio_tone_gen #(
    .TONE_HALF_FRAMES (TONE_HALF_FRAMES),
    .AMPLITUDE        (AMPLITUDE)
  ) u_tone (
    .clk12      (clk12),
    .reset12_   (reset12_),
    .frame_tick (frame_tick_s),
    .sample     (tone_s)
  );

  // Slot decode, capture strobe and next-frame DAC sample selection.
  always_comb begin
    cnt_next_s   = cnt_r + 8'd1;
    slot_s       = cnt_r[6:2];
    slot_next_s  = cnt_next_s[6:2];
    frame_tick_s = (cnt_r == FRAME_END);
    capture_s    = (cnt_r[1:0] == PH_RISE) && is_data_slot(slot_s);
    dac_load_s   = '0;
    dac_word_s   = '0;
    // The right word completes on the same edge it is latched, so take it from the shifter.
    if (LOOPBACK) begin
      dac_load_s.left  = adc_r.left;
      dac_load_s.right = shift_r;
    end else begin
      dac_load_s.left  = tone_s;
      dac_load_s.right = tone_s;
    end
    if (cnt_next_s[7]) begin
      dac_word_s = dac_r.right;
    end else begin
      dac_word_s = dac_r.left;
    end
  end

  // Frame counter, registered clocks/data, ADC shifter and sample latches.
  always_ff @(posedge clk12) begin
    if (!reset12_) begin
      cnt_r    <= 8'd0;
      bclk_r   <= 1'b0;
      lrc_r    <= 1'b0;
      dacdat_r <= 1'b0;
      shift_r  <= 16'h0000;
      adc_r    <= '0;
      dac_r    <= '0;
    end else begin
      cnt_r  <= cnt_next_s;
      bclk_r <= cnt_next_s[1];
      lrc_r  <= cnt_next_s[7];
      if (cnt_next_s[1:0] == PH_FALL) begin
        dacdat_r <= slot_bit(dac_word_s, slot_next_s);
      end
      if (capture_s) begin
        shift_r <= {shift_r[14:0], audio_adcdat};
      end
      if (cnt_r == LEFT_END) begin
        adc_r.left <= shift_r;
      end
      if (frame_tick_s) begin
        adc_r.right <= shift_r;
        dac_r       <= dac_load_s;
      end
    end
  end

  assign audio_mclk   = clk12;
  assign audio_bclk   = bclk_r;
  assign audio_daclrc = lrc_r;
  assign audio_adclrc = lrc_r;
  assign audio_dacdat = dacdat_r;

endmodule

// File: tb/tb_audio_i2s_if.sv
// Self-checking bench: a tone instance and a loopback instance run side by side
// against a frame/slot arithmetic model with a random I2S ADC source.
module tb_audio_i2s_if;

  localparam int          T_HALF = 2;
  localparam logic [15:0] AMP    = 16'h2000;
  localparam int          N_CYC  = 2600;

  logic clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  logic rst_t_n, rst_l_n, adc_t, adc_l;
  logic mclk_t, bclk_t, dlrc_t, ddat_t, alrc_t;
  logic mclk_l, bclk_l, dlrc_l, ddat_l, alrc_l;

  audio_i2s_if #(.LOOPBACK(1'b0), .TONE_HALF_FRAMES(T_HALF), .AMPLITUDE(AMP)) u_tone_dut (
    .clk12(clk12), .reset12_(rst_t_n), .audio_mclk(mclk_t), .audio_bclk(bclk_t),
    .audio_daclrc(dlrc_t), .audio_dacdat(ddat_t), .audio_adclrc(alrc_t), .audio_adcdat(adc_t));

  audio_i2s_if #(.LOOPBACK(1'b1), .TONE_HALF_FRAMES(48), .AMPLITUDE(16'h2000)) u_loop_dut (
    .clk12(clk12), .reset12_(rst_l_n), .audio_mclk(mclk_l), .audio_bclk(bclk_l),
    .audio_daclrc(dlrc_l), .audio_dacdat(ddat_l), .audio_adclrc(alrc_l), .audio_adcdat(adc_l));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Tone value for frame f after reset: frame 0 silent, then AMP/-AMP alternating every T_HALF frames.
  function automatic logic [15:0] tone_word(input int f);
    if (f == 0) return 16'h0000;
    if ((((f - 1) / T_HALF) % 2) == 1) return 16'h0000 - AMP;
    return AMP;
  endfunction

  function automatic logic exp_bit(input logic [15:0] w, input int slot);
    if (slot >= 1 && slot <= 16) return w[16 - slot];
    return 1'b0;
  endfunction

  logic [15:0] lw [0:31];
  logic [15:0] rw [0:31];

  function automatic logic [15:0] loop_word(input int f, input int ch);
    if (f == 0) return 16'h0000;
    if (ch == 1) return rw[f - 1];
    return lw[f - 1];
  endfunction

  int cyc_t, cyc_l, epoch;
  logic [15:0] dec_t, dec_l;
  logic prev_t, prev_l;

  initial begin
    int ph, ft, ch, sl, pl, fl, chl, sll;
    rst_t_n = 1'b0; rst_l_n = 1'b0; adc_t = 1'b0; adc_l = 1'b0;
    cyc_t = 0; cyc_l = 0; epoch = 0;
    dec_t = 16'h0; dec_l = 16'h0; prev_t = 1'b0; prev_l = 1'b0;
    @(posedge clk12);
    for (int k = 0; k < N_CYC; k++) begin
      @(negedge clk12);
      check_val("mclk_lo_t", 32'(mclk_t), 32'(clk12));
      check_val("mclk_lo_l", 32'(mclk_l), 32'(clk12));
      if (k == 3) begin
        rst_t_n = 1'b1;
        rst_l_n = 1'b1;
      end
      if (!rst_l_n && epoch == 1) rst_l_n = 1'b1;

      // tone instance
      ph = cyc_t % 256; ft = cyc_t / 256; ch = ph / 128; sl = (ph % 128) / 4;
      check_val("tone_bclk", 32'(bclk_t), 32'((ph % 4) >= 2));
      check_val("tone_daclrc", 32'(dlrc_t), 32'(ch));
      check_val("tone_adclrc", 32'(alrc_t), 32'(ch));
      check_val("tone_dacdat", 32'(ddat_t), 32'(exp_bit(tone_word(ft), sl)));
      if (ddat_t !== prev_t) check_val("tone_dat_edge", 32'(ph % 4), 32'd0);
      prev_t = ddat_t;
      if ((ph % 4) == 2 && sl >= 1 && sl <= 16) dec_t = {dec_t[14:0], ddat_t};
      if ((ph % 128) == 127) check_val("tone_word", 32'(dec_t), 32'(tone_word(ft)));
      adc_t = 1'($urandom);

      // loopback instance
      pl = cyc_l % 256; fl = cyc_l / 256; chl = pl / 128; sll = (pl % 128) / 4;
      check_val("loop_bclk", 32'(bclk_l), 32'((pl % 4) >= 2));
      check_val("loop_daclrc", 32'(dlrc_l), 32'(chl));
      check_val("loop_adclrc", 32'(alrc_l), 32'(chl));
      check_val("loop_dacdat", 32'(ddat_l), 32'(exp_bit(loop_word(fl, chl), sll)));
      if (ddat_l !== prev_l) check_val("loop_dat_edge", 32'(pl % 4), 32'd0);
      prev_l = ddat_l;
      if ((pl % 4) == 2 && sll >= 1 && sll <= 16) dec_l = {dec_l[14:0], ddat_l};
      if ((pl % 128) == 127) check_val("loop_word", 32'(dec_l), 32'(loop_word(fl, chl)));

      // ADC BFM: pick the frame's words at frame start, drive the slot bit
      if (pl == 0 && fl < 32) begin
        if (epoch == 0 && fl == 1) begin
          lw[fl] = 16'hA5C3;
          rw[fl] = 16'h1234;
        end else begin
          lw[fl] = 16'($urandom);
          rw[fl] = 16'($urandom);
        end
      end
      adc_l = exp_bit((chl == 1) ? rw[fl] : lw[fl], sll);

      // reset mid-frame while the left word sits uncommitted in the shifter
      if (epoch == 0 && fl == 5 && pl == 70) begin
        rst_l_n = 1'b0;
        epoch   = 1;
      end

      @(posedge clk12);
      #1;
      check_val("mclk_hi_t", 32'(mclk_t), 32'(clk12));
      check_val("mclk_hi_l", 32'(mclk_l), 32'(clk12));
      if (rst_t_n) cyc_t++;
      if (rst_l_n) cyc_l++;
      else cyc_l = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
